// File: rtl/cpa_pkg.sv
// rtl/cpa_pkg.sv - shared types, limits and chunk-width helper for the pipelined CPA
//
// Purpose : Chunk-adder architecture selector, legal parameter limits and
//           the chunk-width helper used by cpa_pipe and cpa_chunk.
// Contents: cpa_arch_e, CPA_MAX_BITS, CPA_MAX_STAGES, cpa_chunk_w().
package cpa_pkg;

    typedef enum logic [1:0] {
        CPA_BEHAV,
        CPA_RCA,
        CPA_KS
    } cpa_arch_e;

    localparam int CPA_MAX_BITS   = 128;
    localparam int CPA_MAX_STAGES = 8;

    // ceil(bits / stages)
    function automatic int cpa_chunk_w(input int bits, input int stages);
        return (bits + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/cpa_chunk.sv
// rtl/cpa_chunk.sv - combinational W-bit chunk adder with selectable architecture
//
// Purpose : One W-bit slice of the carry-propagate adder. Purely combinational.
// Ports   : a, b  [W-1:0] in   addends
//           ci            in   carry into bit 0
//           s     [W-1:0] out  sum
//           co            out  carry out of bit W-1
//           c_msb         out  carry into bit W-1 (feeds signed overflow)
module cpa_chunk
    import cpa_pkg::*;
#(
    parameter int        W    = 8,
    parameter cpa_arch_e ARCH = CPA_BEHAV
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [W-1:0] w_s;
    logic         w_co;

    if (ARCH == CPA_RCA) begin : g_rca
        logic [W:0] w_c;

        always_comb begin
            w_c    = '0;
            w_c[0] = ci;
            for (int i = 0; i < W; i++) begin
                w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
            end
        end

        assign w_s  = a ^ b ^ w_c[W-1:0];
        assign w_co = w_c[W];
    end else if (ARCH == CPA_KS) begin : g_ks
        logic [W-1:0] w_p;
        logic [W-1:0] w_gk;
        logic [W-1:0] w_pk;
        logic [W-1:0] w_gt;
        logic [W-1:0] w_pt;
        logic [W:0]   w_cv;

        // Carry-in is folded into bit 0's generate so the prefix result at
        // bit i is directly the carry out of bit i.
        always_comb begin
            w_p     = a ^ b;
            w_gk    = a & b;
            w_gk[0] = w_gk[0] | (w_p[0] & ci);
            w_pk    = w_p;
            w_gt    = '0;
            w_pt    = '0;
            for (int d = 1; d < W; d = d * 2) begin
                w_gt = w_gk;
                w_pt = w_pk;
                for (int i = d; i < W; i++) begin
                    w_gt[i] = w_gk[i] | (w_pk[i] & w_gk[i-d]);
                    w_pt[i] = w_pk[i] & w_pk[i-d];
                end
                w_gk = w_gt;
                w_pk = w_pt;
            end
        end

        assign w_cv = {w_gk, ci};
        assign w_s  = w_p ^ w_cv[W-1:0];
        assign w_co = w_cv[W];
    end else begin : g_behav
        assign {w_co, w_s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    end

    assign s     = w_s;
    assign co    = w_co;
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB is recoverable
    // from the MSB alone; for W=1 this reduces to ci.
    assign c_msb = a[W-1] ^ b[W-1] ^ w_s[W-1];

endmodule

// File: rtl/cpa_pipe.sv
// rtl/cpa_pipe.sv - pipelined carry-propagate adder/subtractor with valid/ready handshake
//
// Purpose : BITS-wide add/subtract split into STAGES carry-pipelined chunks.
// Ports   : clk, rst_n        clock, synchronous active-low reset
//           in_valid/in_ready operand handshake
//           a, b [BITS-1:0]   operands; ci carry-in (add only); sub selects a-b
//           out_valid/out_ready result handshake
//           s [BITS-1:0]      sum/difference; co carry-out (sub: 1 = no borrow)
//           ovf               two's-complement signed overflow
module cpa_pipe
    import cpa_pkg::*;
#(
    parameter int        BITS   = 32,
    parameter int        STAGES = 2,
    parameter cpa_arch_e ARCH   = CPA_BEHAV
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            ci,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] s,
    output logic            co,
    output logic            ovf
);

    localparam int CW = cpa_chunk_w(BITS, STAGES);

    if (BITS < 1 || BITS > CPA_MAX_BITS || STAGES < 1 || STAGES > CPA_MAX_STAGES ||
        STAGES > BITS || (STAGES * CW - CW) >= BITS) begin : g_bad_params
        $error("cpa_pipe: illegal BITS/STAGES combination");
    end

    // Per-stage registers: operands keep the not-yet-added upper chunks,
    // r_s accumulates the finished lower chunks, r_c is the chunk carry.
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_c;
    logic [BITS-1:0]   r_a [STAGES];
    logic [BITS-1:0]   r_b [STAGES];
    logic [BITS-1:0]   r_s [STAGES];
    logic              r_ovf;

    logic [STAGES-1:0] w_ld;
    logic [STAGES-1:0] w_v_i;
    logic [STAGES-1:0] w_c_i;
    logic [STAGES-1:0] w_co;
    logic              w_cm  [STAGES];
    logic [BITS-1:0]   w_a_i [STAGES];
    logic [BITS-1:0]   w_b_i [STAGES];
    logic [BITS-1:0]   w_s_i [STAGES];
    logic [BITS-1:0]   w_s_o [STAGES];

    // A stage loads when it is empty or its successor loads, so bubbles
    // collapse and a stalled output back-pressures only the full stages.
    always_comb begin
        w_ld           = '0;
        w_ld[STAGES-1] = ~r_valid[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_ld[k] = ~r_valid[k] | w_ld[k+1];
        end
    end

    always_comb begin
        w_v_i    = '0;
        w_c_i    = '0;
        w_a_i[0] = a;
        w_b_i[0] = sub ? ~b : b;
        w_s_i[0] = '0;
        w_c_i[0] = sub | ci;
        w_v_i[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_a_i[k] = r_a[k-1];
            w_b_i[k] = r_b[k-1];
            w_s_i[k] = r_s[k-1];
            w_c_i[k] = r_c[k-1];
            w_v_i[k] = r_valid[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CW;
        localparam int HI = ((k + 1) * CW < BITS) ? (k + 1) * CW : BITS;
        localparam int WK = HI - LO;
        localparam logic [BITS-1:0] MASK = ({BITS{1'b1}} >> (BITS - WK)) << LO;

        logic [WK-1:0] w_sum;

        cpa_chunk #(
            .W    (WK),
            .ARCH (ARCH)
        ) u_chunk (
            .a     (w_a_i[k][HI-1:LO]),
            .b     (w_b_i[k][HI-1:LO]),
            .ci    (w_c_i[k]),
            .s     (w_sum),
            .co    (w_co[k]),
            .c_msb (w_cm[k])
        );

        assign w_s_o[k] = (w_s_i[k] & ~MASK) | (BITS'(w_sum) << LO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_c     <= '0;
            r_ovf   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ld[k]) begin
                    r_valid[k] <= w_v_i[k];
                    r_a[k]     <= w_a_i[k];
                    r_b[k]     <= w_b_i[k];
                    r_s[k]     <= w_s_o[k];
                    r_c[k]     <= w_co[k];
                end
            end
            if (w_ld[STAGES-1]) begin
                r_ovf <= w_cm[STAGES-1] ^ w_co[STAGES-1];
            end
        end
    end

    assign in_ready  = w_ld[0];
    assign out_valid = r_valid[STAGES-1];
    assign s         = r_s[STAGES-1];
    assign co        = r_c[STAGES-1];
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_cpa_pipe.sv
// tb/tb_cpa_pipe.sv - directed and random self-checking bench for cpa_pipe
module tb_cpa_pipe;
    import cpa_pkg::*;

    logic clk;
    logic rst_n;

    // 32-bit group: d0 (4 stages, KS), d1 (1 stage, BEHAV), d5 (1 bit, KS)
    logic        in_valid, out_ready, ci, sub;
    logic [31:0] a32, b32;
    logic        rdy0, ov0, co0, ovf0;
    logic [31:0] s0;
    logic        rdy1, ov1, co1, ovf1;
    logic [31:0] s1;
    logic        rdy5, ov5, co5, ovf5;
    logic [0:0]  s5;

    // 33-bit group, 4 stages (CW=9, last chunk 6 bits), one per architecture
    logic        iv33, or33, ci33, sub33;
    logic [32:0] a33, b33;
    logic [2:0]  rdy33, ov33, co33, ovf33;
    logic [32:0] s33 [3];

    cpa_pipe #(.BITS(32), .STAGES(4), .ARCH(CPA_KS)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .a(a32), .b(b32), .ci(ci), .sub(sub), .out_valid(ov0),
        .out_ready(out_ready), .s(s0), .co(co0), .ovf(ovf0));

    cpa_pipe #(.BITS(32), .STAGES(1), .ARCH(CPA_BEHAV)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .a(a32), .b(b32), .ci(ci), .sub(sub), .out_valid(ov1),
        .out_ready(out_ready), .s(s1), .co(co1), .ovf(ovf1));

    cpa_pipe #(.BITS(1), .STAGES(1), .ARCH(CPA_KS)) u_d5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy5),
        .a(a32[0]), .b(b32[0]), .ci(ci), .sub(sub), .out_valid(ov5),
        .out_ready(out_ready), .s(s5), .co(co5), .ovf(ovf5));

    cpa_pipe #(.BITS(33), .STAGES(4), .ARCH(CPA_BEHAV)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv33), .in_ready(rdy33[0]),
        .a(a33), .b(b33), .ci(ci33), .sub(sub33), .out_valid(ov33[0]),
        .out_ready(or33), .s(s33[0]), .co(co33[0]), .ovf(ovf33[0]));

    cpa_pipe #(.BITS(33), .STAGES(4), .ARCH(CPA_RCA)) u_r (
        .clk(clk), .rst_n(rst_n), .in_valid(iv33), .in_ready(rdy33[1]),
        .a(a33), .b(b33), .ci(ci33), .sub(sub33), .out_valid(ov33[1]),
        .out_ready(or33), .s(s33[1]), .co(co33[1]), .ovf(ovf33[1]));

    cpa_pipe #(.BITS(33), .STAGES(4), .ARCH(CPA_KS)) u_k (
        .clk(clk), .rst_n(rst_n), .in_valid(iv33), .in_ready(rdy33[2]),
        .a(a33), .b(b33), .ci(ci33), .sub(sub33), .out_valid(ov33[2]),
        .out_ready(or33), .s(s33[2]), .co(co33[2]), .ovf(ovf33[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns {ovf, co, s} for a bits-wide add/subtract.
    function automatic logic [63:0] ref_add(input logic [63:0] ra, input logic [63:0] rb,
                                            input logic rci, input logic rsub, input int bits);
        logic [63:0] mask, beff, sum;
        logic        cin, rco, cm;
        mask = (64'd1 << bits) - 64'd1;
        beff = (rsub ? ~rb : rb) & mask;
        cin  = rsub ? 1'b1 : rci;
        sum  = (ra & mask) + beff + 64'(cin);
        rco  = sum[bits];
        cm   = ra[bits-1] ^ beff[bits-1] ^ sum[bits-1];
        return (64'(cm ^ rco) << (bits + 1)) | (64'(rco) << bits) | (sum & mask);
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    vec_t vecs [12];

    // Called at a negedge: offers one operand pair, then checks the 1-stage
    // instances after one cycle and the 4-stage instance after exactly four.
    task automatic run_vec(input int idx);
        vec_t v;
        int   n;
        bit   got;
        v = vecs[idx];
        a32 = v.a; b32 = v.b; ci = v.ci; sub = v.sub;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("vec_in_ready", 64'(rdy0), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n = 1;
        got = 0;
        chk("vec_s1_valid", 64'(ov1), 64'd1);
        chk("vec_s1_result", {ovf1, co1, s1}, {v.ovf, v.co, v.s});
        chk("vec_bit1_valid", 64'(ov5), 64'd1);
        chk("vec_bit1_result", {ovf5, co5, s5}, ref_add(64'(v.a[0]), 64'(v.b[0]), v.ci, v.sub, 1));
        while (!got && n <= 20) begin
            if (ov0) begin
                chk("vec_latency", 64'(n), 64'd4);
                chk("vec_result", {ovf0, co0, s0}, {v.ovf, v.co, v.s});
                got = 1;
            end else begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        if (!got) chk("vec_timeout", 64'd0, 64'd1);
    endtask

    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] q2[$];

    initial begin
        int          sent, recv, n_sent, qs;
        bit          stalled, saw_full;
        logic [31:0] held;
        logic [63:0] e, x;
        string       rnames [3];

        rnames = '{"rand_behav", "rand_rca", "rand_ks"};

        vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[4]  = '{32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0};
        vecs[5]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
        vecs[6]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[8]  = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0};
        vecs[9]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
        vecs[10] = '{32'h1234_5678, 32'h1234_5679, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[11] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a32 = '0; b32 = '0; ci = 1'b0; sub = 1'b0;
        iv33 = 1'b0; or33 = 1'b1; a33 = '0; b33 = '0; ci33 = 1'b0; sub33 = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_out_valid", 64'(ov0), 64'd0);
        chk("reset_result", {ovf0, co0, s0}, 64'd0);
        chk("reset_in_ready", 64'(rdy0), 64'd1);
        chk("reset_out_valid_33", 64'(ov33), 64'd0);
        rst_n = 1'b1;

        // Directed vectors: results and latency
        for (int i = 0; i < 12; i++) run_vec(i);

        // Back-pressure stream (i, 3i), output stalled in cycles 5..7
        sent = 0; recv = 0; stalled = 0; saw_full = 0; held = '0;
        for (int c = 1; c <= 40 && recv < 6; c++) begin
            @(negedge clk);
            out_ready = !(c >= 5 && c <= 7);
            in_valid  = (sent < 6);
            a32 = 32'(sent + 1); b32 = 32'(3 * (sent + 1)); ci = 1'b0; sub = 1'b0;
            #1;
            if (stalled) begin
                chk("bp_hold_valid", 64'(ov0), 64'd1);
                chk("bp_hold_s", 64'(s0), 64'(held));
            end
            if (in_valid && !rdy0) saw_full = 1;
            if (ov0 && out_ready) begin
                chk("bp_seq", 64'(s0), 64'(4 * (recv + 1)));
                recv++;
            end
            stalled = ov0 && !out_ready;
            held = s0;
            if (in_valid && rdy0) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_count", 64'(recv), 64'd6);
        chk("bp_in_ready_fell", 64'(saw_full), 64'd1);

        // Reset mid-stream after three accepted inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a32 = 32'(100 + i); b32 = 32'd7; ci = 1'b0; sub = 1'b0;
            #1;
            chk("rst_accept", 64'(rdy0), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("rst_pre_valid", 64'(ov0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 64'(ov0), 64'd0);
        chk("rst_result", {ovf0, co0, s0}, 64'd0);
        chk("rst_in_ready", 64'(rdy0), 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            chk("rst_no_stale", 64'(ov0), 64'd0);
        end

        // Random 33-bit stream against all three architectures
        n_sent = 0;
        for (int c = 0; c < 60000; c++) begin
            @(negedge clk);
            or33  = ($urandom_range(0, 3) != 0);
            iv33  = (n_sent < 10000) && ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       a33 = {33{1'b1}};
                1:       a33 = 33'h1_0000_0000;
                2:       a33 = 33'h0_FFFF_FFFF;
                default: a33 = 33'({$urandom(), $urandom()});
            endcase
            case ($urandom_range(0, 7))
                0:       b33 = {33{1'b1}};
                1:       b33 = 33'd0;
                2:       b33 = 33'd1;
                default: b33 = 33'({$urandom(), $urandom()});
            endcase
            ci33  = 1'($urandom_range(0, 1));
            sub33 = 1'($urandom_range(0, 1));
            #1;
            e = ref_add(64'(a33), 64'(b33), ci33, sub33, 33);
            for (int d = 0; d < 3; d++) begin
                if (ov33[d] && or33) begin
                    case (d)
                        0:       qs = q0.size();
                        1:       qs = q1.size();
                        default: qs = q2.size();
                    endcase
                    if (qs == 0) begin
                        chk({rnames[d], "_spurious"}, 64'd1, 64'd0);
                    end else begin
                        case (d)
                            0:       x = q0.pop_front();
                            1:       x = q1.pop_front();
                            default: x = q2.pop_front();
                        endcase
                        chk(rnames[d], {ovf33[d], co33[d], s33[d]}, x);
                    end
                end
                if (iv33 && rdy33[d]) begin
                    case (d)
                        0:       q0.push_back(e);
                        1:       q1.push_back(e);
                        default: q2.push_back(e);
                    endcase
                end
            end
            if (iv33 && rdy33[0]) n_sent++;
            if (n_sent >= 10000 && q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
        end
        iv33 = 1'b0;
        chk("rand_sent", 64'(n_sent), 64'd10000);
        chk("rand_drain_behav", 64'(q0.size()), 64'd0);
        chk("rand_drain_rca", 64'(q1.size()), 64'd0);
        chk("rand_drain_ks", 64'(q2.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
